fetch_redirect_ctrl: RTL and testbench
======================================

FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 0, the fetch PC loaded on reset.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the redirect counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port stall_i, input, 1, backend stall.
REQ-006 SHALL have port ctiQueueFull_i, input, 1, CTI queue full; blocks fetch advance.
REQ-007 SHALL have port flagRecoverEX_i, input, 1, execute-stage misprediction recovery.
REQ-008 SHALL have port targetAddrEX_i, input, `SIZE_PC, the execute recovery target.
REQ-009 SHALL have port flagRecoverID_i, input, 1, FS2 predecode recovery.
REQ-010 SHALL have port targetAddrID_i, input, `SIZE_PC, the FS2 recovery target.
REQ-011 SHALL have port predTaken_i, input, 1, BTB/predictor taken for the current bundle.
REQ-012 SHALL have port predTarget_i, input, `SIZE_PC, the predicted target.
REQ-013 SHALL have port pc_o, output, `SIZE_PC, the registered fetch PC.
REQ-014 SHALL have port fetchValid_o, output, 1, meaning pc_o is a valid fetch request this cycle.
REQ-015 SHALL have port holdPending_o, output, 1, meaning an ID redirect is captured and waiting.
REQ-016 SHALL have port redirectCount_o, output, CNT_W, the count of applied redirects.

Function
REQ-017 SHALL define advance = ~stall_i & ~ctiQueueFull_i.
REQ-018 SHALL resolve next PC in priority order: EX recovery > pending ID > live ID recovery > predTaken_i > sequential pc_o+32, with `SIZE_PC wrap on overflow.
REQ-019 SHALL implement FSM states RUN, HOLD and BUBBLE (BUBBLE only per REQ-030); the state encoding is free.
REQ-020 SHALL, on flagRecoverEX_i in any state, load pc_o <= targetAddrEX_i next cycle regardless of advance, clear pending, increment the counter and enter RUN (BUBBLE if enabled).
REQ-021 SHALL, in RUN with flagRecoverID_i, no EX recovery and advance=1, load pc_o <= targetAddrID_i and increment the counter.
REQ-022 SHALL, in RUN with flagRecoverID_i, no EX recovery and advance=0, capture targetAddrID_i into the pending register, hold pc_o and enter HOLD.
REQ-023 SHALL, in HOLD with advance=1 and no EX recovery, load pc_o <= pending, clear pending, increment the counter and enter RUN (BUBBLE if enabled).
REQ-024 SHALL, in HOLD, ignore a new flagRecoverID_i; the first captured target wins.
REQ-025 SHALL, in RUN with advance=1 and no recovery, load predTarget_i if predTaken_i is set, otherwise pc_o+32.
REQ-026 SHALL hold pc_o whenever advance=0 and no redirect applies.
REQ-027 SHALL drive fetchValid_o = 1 in RUN only, registered; SHALL drive it 0 in HOLD and BUBBLE; SHALL drive holdPending_o = 1 exactly while in HOLD.
REQ-028 SHALL make redirectCount_o saturate at all-ones, never wrap, and count an EX and ID redirect in the same cycle as one.

Reset
REQ-029 SHALL, on reset high at a clock edge, override all other inputs: pc_o=RESET_PC, state=RUN, fetchValid_o=1, holdPending_o=0, pending=0, redirectCount_o=0, including mid-HOLD or mid-BUBBLE.

Configuration
REQ-030 SHALL, with macro FETCH_REDIRECT_BUBBLE_EN defined, enter BUBBLE for exactly one cycle after any applied redirect (fetchValid_o=0, pc_o stable), then return to RUN; an EX recovery during BUBBLE redirects again and restarts BUBBLE; without the macro, the BUBBLE state does not exist and redirects go directly to RUN.

Verification
REQ-031 SHALL cover reset release with no events: pc_o = 0x0, 0x20, 0x40 on consecutive cycles with fetchValid_o=1.
REQ-032 SHALL cover predTaken_i=1 with predTarget_i=0x400 at pc_o=0x40: next pc_o=0x400, counter unchanged.
REQ-033 SHALL cover flagRecoverID_i with targetAddrID_i=0x800 while stall_i=1 for 3 cycles: HOLD, holdPending_o=1, pc_o held, then pc_o=0x800 one cycle after stall drops, counter=1.
REQ-034 SHALL cover flagRecoverEX_i with targetAddrEX_i=0xC00 during HOLD with pending 0x800: next pc_o=0xC00, holdPending_o=0, 0x800 never issued.
REQ-035 SHALL cover simultaneous EX (0x100) and ID (0x200) recovery: pc_o=0x100, counter +1.
REQ-036 SHALL cover counter preset near saturation via CNT_W=2 with 5 redirects: redirectCount_o=3; with FETCH_REDIRECT_BUBBLE_EN, each redirect shows one fetchValid_o=0 cycle.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: merges EX/ID recoveries, branch prediction and stalls into the next fetch PC.
// Optional macro FETCH_REDIRECT_BUBBLE_EN inserts a one-cycle fetch bubble after each applied redirect.

`ifndef SIZE_PC
`define SIZE_PC 32
`endif

module fetch_redirect_ctrl #(
    parameter logic [`SIZE_PC-1:0] RESET_PC = '0,
    parameter int                  CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_i,
    input  logic                ctiQueueFull_i,
    input  logic                flagRecoverEX_i,
    input  logic [`SIZE_PC-1:0] targetAddrEX_i,
    input  logic                flagRecoverID_i,
    input  logic [`SIZE_PC-1:0] targetAddrID_i,
    input  logic                predTaken_i,
    input  logic [`SIZE_PC-1:0] predTarget_i,
    output logic [`SIZE_PC-1:0] pc_o,
    output logic                fetchValid_o,
    output logic                holdPending_o,
    output logic [CNT_W-1:0]    redirectCount_o
);

`ifdef FETCH_REDIRECT_BUBBLE_EN
    typedef enum logic [1:0] {RUN, HOLD, BUBBLE} state_t;
    localparam state_t POST_REDIRECT = BUBBLE;
`else
    typedef enum logic [1:0] {RUN, HOLD} state_t;
    localparam state_t POST_REDIRECT = RUN;
`endif

    state_t              state_q, state_d;
    logic [`SIZE_PC-1:0] pc_q, pc_d;
    logic [`SIZE_PC-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                fetch_valid_q, fetch_valid_d;
    logic                hold_pending_q, hold_pending_d;
    logic                advance;
    logic                redirect;

    assign advance = ~stall_i & ~ctiQueueFull_i;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        redirect  = 1'b0;

        if (flagRecoverEX_i) begin
            // EX recovery outranks everything, including a captured ID target.
            pc_d      = targetAddrEX_i;
            pending_d = '0;
            redirect  = 1'b1;
            state_d   = POST_REDIRECT;
        end else begin
            case (state_q)
                RUN: begin
                    if (flagRecoverID_i) begin
                        if (advance) begin
                            pc_d     = targetAddrID_i;
                            redirect = 1'b1;
                            state_d  = POST_REDIRECT;
                        end else begin
                            pending_d = targetAddrID_i;
                            state_d   = HOLD;
                        end
                    end else if (advance) begin
                        pc_d = predTaken_i ? predTarget_i : pc_q + `SIZE_PC'(32);
                    end
                end
                HOLD: begin
                    // Later ID recoveries are dropped; the captured target is released once fetch can move.
                    if (advance) begin
                        pc_d      = pending_q;
                        pending_d = '0;
                        redirect  = 1'b1;
                        state_d   = POST_REDIRECT;
                    end
                end
`ifdef FETCH_REDIRECT_BUBBLE_EN
                BUBBLE: state_d = RUN;
`endif
                default: state_d = RUN;
            endcase
        end

        count_d = count_q;
        if (redirect && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end

        fetch_valid_d  = (state_d == RUN);
        hold_pending_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            pc_q           <= RESET_PC;
            pending_q      <= '0;
            count_q        <= '0;
            fetch_valid_q  <= 1'b1;
            hold_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pending_q      <= pending_d;
            count_q        <= count_d;
            fetch_valid_q  <= fetch_valid_d;
            hold_pending_q <= hold_pending_d;
        end
    end

    assign pc_o            = pc_q;
    assign fetchValid_o    = fetch_valid_q;
    assign holdPending_o   = hold_pending_q;
    assign redirectCount_o = count_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: directed scenarios then random traffic against a queue-based model.
// Honours FETCH_REDIRECT_BUBBLE_EN the same way as the design.

`ifndef SIZE_PC
`define SIZE_PC 32
`endif

module tb_fetch_redirect_ctrl;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                stall_i = 1'b0;
    logic                ctiQueueFull_i = 1'b0;
    logic                flagRecoverEX_i = 1'b0;
    logic [`SIZE_PC-1:0] targetAddrEX_i = '0;
    logic                flagRecoverID_i = 1'b0;
    logic [`SIZE_PC-1:0] targetAddrID_i = '0;
    logic                predTaken_i = 1'b0;
    logic [`SIZE_PC-1:0] predTarget_i = '0;
    logic [`SIZE_PC-1:0] pc_o, pc_sat;
    logic                fetchValid_o, fv_sat;
    logic                holdPending_o, hp_sat;
    logic [15:0]         redirectCount_o;
    logic [1:0]          cnt_sat;

    always #5 clk = ~clk;

    fetch_redirect_ctrl dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .ctiQueueFull_i(ctiQueueFull_i),
        .flagRecoverEX_i(flagRecoverEX_i), .targetAddrEX_i(targetAddrEX_i),
        .flagRecoverID_i(flagRecoverID_i), .targetAddrID_i(targetAddrID_i),
        .predTaken_i(predTaken_i), .predTarget_i(predTarget_i),
        .pc_o(pc_o), .fetchValid_o(fetchValid_o), .holdPending_o(holdPending_o),
        .redirectCount_o(redirectCount_o)
    );

    fetch_redirect_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .stall_i(stall_i), .ctiQueueFull_i(ctiQueueFull_i),
        .flagRecoverEX_i(flagRecoverEX_i), .targetAddrEX_i(targetAddrEX_i),
        .flagRecoverID_i(flagRecoverID_i), .targetAddrID_i(targetAddrID_i),
        .predTaken_i(predTaken_i), .predTarget_i(predTarget_i),
        .pc_o(pc_sat), .fetchValid_o(fv_sat), .holdPending_o(hp_sat),
        .redirectCount_o(cnt_sat)
    );

    typedef struct {
        logic [31:0] pc;
        bit          valid;
        bit          hold;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: a waiting ID target is simply an entry in a queue.
    logic [31:0] m_pc = 0;
    logic [31:0] m_pend[$];
    bit          m_bubble = 0;
    int          m_cnt = 0;
`ifdef FETCH_REDIRECT_BUBBLE_EN
    localparam bit BUBBLE_EN = 1'b1;
`else
    localparam bit BUBBLE_EN = 1'b0;
`endif

    task automatic model_step();
        bit adv, red;
        exp_t e;
        if (reset) begin
            m_pc = 0; m_pend.delete(); m_bubble = 0; m_cnt = 0;
        end else begin
            adv = !stall_i && !ctiQueueFull_i;
            red = 0;
            if (flagRecoverEX_i) begin
                m_pc = targetAddrEX_i; m_pend.delete(); red = 1;
            end else if (m_bubble) begin
                // pc stays put for the bubble cycle
            end else if (m_pend.size() > 0) begin
                if (adv) begin m_pc = m_pend.pop_front(); red = 1; end
            end else if (flagRecoverID_i) begin
                if (adv) begin m_pc = targetAddrID_i; red = 1; end
                else m_pend.push_back(targetAddrID_i);
            end else if (adv) begin
                m_pc = predTaken_i ? predTarget_i : m_pc + 32'd32;
            end
            m_bubble = BUBBLE_EN && red;
            if (red) m_cnt++;
        end
        e.pc = m_pc; e.valid = (m_pend.size() == 0) && !m_bubble;
        e.hold = m_pend.size() > 0; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit rst, input bit st, input bit cti,
                         input bit ex, input logic [31:0] tex,
                         input bit id, input logic [31:0] tid,
                         input bit pt, input logic [31:0] ptg);
        @(negedge clk);
        reset = rst; stall_i = st; ctiQueueFull_i = cti;
        flagRecoverEX_i = ex; targetAddrEX_i = tex;
        flagRecoverID_i = id; targetAddrID_i = tid;
        predTaken_i = pt; predTarget_i = ptg;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a new registered output set.
    initial begin
        exp_t e;
        int   sat_exp, wide_exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                wide_exp = (e.cnt > 65535) ? 65535 : e.cnt;
                sat_exp  = (e.cnt > 3) ? 3 : e.cnt;
                tests += 5;
                if (pc_o !== e.pc) begin
                    fails++; $display("FAIL pc: got %h expected %h", pc_o, e.pc);
                end
                if (fetchValid_o !== e.valid) begin
                    fails++; $display("FAIL fetchValid: got %b expected %b (pc %h)", fetchValid_o, e.valid, e.pc);
                end
                if (holdPending_o !== e.hold) begin
                    fails++; $display("FAIL holdPending: got %b expected %b (pc %h)", holdPending_o, e.hold, e.pc);
                end
                if (redirectCount_o !== 16'(wide_exp)) begin
                    fails++; $display("FAIL count: got %0d expected %0d", redirectCount_o, wide_exp);
                end
                if (cnt_sat !== 2'(sat_exp)) begin
                    fails++; $display("FAIL sat_count: got %0d expected %0d", cnt_sat, sat_exp);
                end
                $display("[TB] cyc pc=%h v=%b h=%b cnt=%0d sat=%0d", pc_o, fetchValid_o, holdPending_o, redirectCount_o, cnt_sat);
            end
        end
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Sequential fetch 0x20, 0x40, then a predicted-taken jump to 0x400.
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h400);
        // ID recovery under a three-cycle stall, released when the stall drops.
        drive(0, 1, 0, 0, 0, 1, 32'h800, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 32'h880, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // EX recovery overriding a captured ID target.
        drive(0, 1, 0, 0, 0, 1, 32'h800, 0, 0);
        drive(0, 0, 1, 1, 32'hC00, 0, 0, 0, 0);
        idle(2);
        // Simultaneous EX and ID recoveries count once.
        drive(0, 0, 0, 1, 32'h100, 1, 32'h200, 0, 0);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 32'h1000 + 32'(i) * 32'h40, 0, 0, 0, 0);
            idle(1);
        end
        // Reset in the middle of a HOLD.
        drive(0, 1, 0, 0, 0, 1, 32'h3000, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Wrap of the sequential increment.
        drive(0, 0, 0, 1, 32'hFFFF_FFF0, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0), $urandom,
                  ($urandom_range(0, 7) == 0), $urandom,
                  ($urandom_range(0, 3) == 0), $urandom);
        end
        idle(1);
        repeat (3) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
